// File: rtl/sync_fifo_stream_reader.sv
// sync_fifo_stream_reader
//
// Read-side controller for a synchronous FIFO with a registered, one-cycle
// read latency. Read strobes are issued only when the returning word is
// guaranteed a place in a 2-entry skid buffer. The buffer is re-timed into a
// valid/ready stream. Rows of ROW_LEN words are tagged with m_last and counted
// in row_cnt.
//
// Ports
//   clk         clock, all logic on the rising edge
//   rst         asynchronous active-high reset
//   clear       synchronous flush of reader state (FIFO contents untouched)
//   fifo_empty  FIFO empty status; gates read issue
//   fifo_rd_en  FIFO read strobe; data arrives on fifo_data the next cycle
//   fifo_data   FIFO registered read data
//   m_valid     stream word valid
//   m_ready     downstream accept
//   m_data      stream word (always the oldest buffered word)
//   m_last      marks the last word of each row
//   row_cnt     completed rows, wraps modulo 2^CNT_WIDTH
module sync_fifo_stream_reader #(
   parameter int DATA_WIDTH = 25,
   parameter int ROW_LEN    = 61,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last,
   output logic [CNT_WIDTH-1:0]  row_cnt
);

   // Column counter needs at least one bit even when ROW_LEN is 1.
   localparam int COL_WIDTH = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
   localparam logic [COL_WIDTH-1:0] COL_MAX = COL_WIDTH'(ROW_LEN - 1);

   logic [DATA_WIDTH-1:0] slot0_reg, slot0_next;
   logic [DATA_WIDTH-1:0] slot1_reg, slot1_next;
   logic [1:0]            occ_reg, occ_next;
   logic                  inflight_reg;
   logic [COL_WIDTH-1:0]  col_reg, col_next;
   logic [CNT_WIDTH-1:0]  row_cnt_reg, row_cnt_next;

   logic                  pop;
   logic [1:0]            occ_after_pop;
   logic [2:0]            committed;

   assign m_valid = (occ_reg != 2'd0) & ~clear;
   assign pop     = m_valid & m_ready;

   // Slots that will still be claimed after this cycle's pop, counting the
   // word already in flight. A new read is issued only if one slot remains.
   assign committed  = {1'b0, occ_reg} + {2'b00, inflight_reg} - {2'b00, pop};
   assign fifo_rd_en = ~rst & ~clear & ~fifo_empty & (committed <= 3'd1);

   assign occ_after_pop = occ_reg - {1'b0, pop};

   assign m_data  = slot0_reg;
   assign m_last  = m_valid & (col_reg == COL_MAX);
   assign row_cnt = row_cnt_reg;

   always_comb begin
      slot0_next   = slot0_reg;
      slot1_next   = slot1_reg;
      occ_next     = occ_after_pop;
      col_next     = col_reg;
      row_cnt_next = row_cnt_reg;

      // Popping from a full buffer promotes the skid word to the output slot.
      if (pop && (occ_reg == 2'd2)) begin
         slot0_next = slot1_reg;
      end

      // The returning word lands in the lowest slot left free by the pop.
      if (inflight_reg) begin
         if (occ_after_pop == 2'd0) begin
            slot0_next = fifo_data;
         end else begin
            slot1_next = fifo_data;
         end
         occ_next = occ_after_pop + 2'd1;
      end

      if (pop) begin
         if (col_reg == COL_MAX) begin
            col_next     = '0;
            row_cnt_next = row_cnt_reg + CNT_WIDTH'(1);
         end else begin
            col_next = col_reg + COL_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot0_reg    <= '0;
         slot1_reg    <= '0;
         occ_reg      <= 2'd0;
         inflight_reg <= 1'b0;
         col_reg      <= '0;
         row_cnt_reg  <= '0;
      end else if (clear) begin
         // Dropping inflight discards the word that returns next cycle.
         occ_reg      <= 2'd0;
         inflight_reg <= 1'b0;
         col_reg      <= '0;
         row_cnt_reg  <= '0;
      end else begin
         slot0_reg    <= slot0_next;
         slot1_reg    <= slot1_next;
         occ_reg      <= occ_next;
         inflight_reg <= fifo_rd_en;
         col_reg      <= col_next;
         row_cnt_reg  <= row_cnt_next;
      end
   end

endmodule

// File: tb/tb_sync_fifo_stream_reader.sv
// Testbench for sync_fifo_stream_reader: a queue-based FIFO with one-cycle
// registered read latency feeds the DUT; a scoreboard of issued words, an
// accepted-word count and row arithmetic give the expected stream.
module tb_sync_fifo_stream_reader;
   localparam int DW = 25;
   localparam int RL = 61;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          clear;
   logic          fifo_empty;
   logic          fifo_rd_en;
   logic [DW-1:0] fifo_data;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
   logic          m_last;
   logic [CW-1:0] row_cnt;

   always #5 clk = ~clk;

   sync_fifo_stream_reader #(
      .DATA_WIDTH(DW),
      .ROW_LEN   (RL),
      .CNT_WIDTH (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .fifo_empty(fifo_empty),
      .fifo_rd_en(fifo_rd_en),
      .fifo_data (fifo_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .m_last    (m_last),
      .row_cnt   (row_cnt)
   );

   int            n_cmp = 0;
   int            n_bad = 0;
   logic [DW-1:0] fq[$];      // FIFO contents not yet read
   logic [DW-1:0] exp_q[$];   // words read from the FIFO, not yet accepted
   int            acc = 0;    // words accepted since last reset/clear
   bit            hold_prev = 1'b0;
   logic [DW-1:0] held_data = '0;

   task automatic chk(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic push(input logic [DW-1:0] v);
      fq.push_back(v);
      fifo_empty = 1'b0;
   endtask

   // One clock cycle: sample and check at the falling edge, then advance the
   // FIFO and the reference model just after the rising edge.
   task automatic tick(output bit s_rd, output bit s_valid, output int s_data, output bit s_last);
      bit s_pop;
      int s_rc;
      @(negedge clk);
      s_rd    = fifo_rd_en;
      s_valid = m_valid;
      s_data  = int'(m_data);
      s_last  = m_last;
      s_rc    = int'(row_cnt);
      s_pop   = s_valid & m_ready;
      if (rst) begin
         chk("rst_rd_en", int'(s_rd), 0);
         chk("rst_valid", int'(s_valid), 0);
         chk("rst_data", s_data, 0);
         chk("rst_last", int'(s_last), 0);
         chk("rst_row_cnt", s_rc, 0);
      end else if (clear) begin
         chk("clear_rd_en", int'(s_rd), 0);
         chk("clear_valid", int'(s_valid), 0);
      end else begin
         if (s_rd) chk("rd_while_empty", int'(fifo_empty), 0);
         chk("row_cnt", s_rc, (acc / RL) % (1 << CW));
         chk("in_use_le_2", (exp_q.size() + int'(s_rd) - int'(s_pop) <= 2) ? 1 : 0, 1);
         if (hold_prev) begin
            chk("hold_valid", int'(s_valid), 1);
            chk("hold_data", s_data, int'(held_data));
         end
         if (s_valid) begin
            chk("valid_has_word", (exp_q.size() > 0) ? 1 : 0, 1);
            if (exp_q.size() > 0) chk("data", s_data, int'(exp_q[0]));
            chk("last", int'(s_last), ((acc % RL) == RL - 1) ? 1 : 0);
         end else begin
            chk("last_idle", int'(s_last), 0);
         end
      end
      hold_prev = !rst && !clear && s_valid && !m_ready;
      held_data = DW'(s_data);
      @(posedge clk);
      #1;
      if (rst || clear) begin
         exp_q.delete();
         acc = 0;
      end else begin
         if (s_pop && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            acc++;
         end
         if (s_rd && fq.size() > 0) begin
            fifo_data = fq.pop_front();
            exp_q.push_back(fifo_data);
         end
      end
      fifo_empty = (fq.size() == 0);
   endtask

   task automatic do_reset();
      bit r, v, l;
      int d;
      rst = 1'b1;
      tick(r, v, d, l);
      tick(r, v, d, l);
      rst = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      bit r, v, l;
      int d, first, last, nl, nrd, nv, n, got;
      rst        = 1'b1;
      clear      = 1'b0;
      m_ready    = 1'b0;
      fifo_data  = '0;
      fifo_empty = 1'b1;

      // Reset with three words waiting in the FIFO.
      push(25'd1); push(25'd2); push(25'd3);
      for (int i = 0; i < 3; i++) tick(r, v, d, l);
      rst = 1'b0;
      tick(r, v, d, l);
      chk("rel_rd_en_c0", int'(r), 1);
      chk("rel_valid_c0", int'(v), 0);
      tick(r, v, d, l);
      chk("rel_valid_c1", int'(v), 0);
      tick(r, v, d, l);
      chk("rel_valid_c2", int'(v), 1);
      chk("rel_data_c2", d, 1);

      // Full-rate streaming of two rows.
      do_reset();
      fq.delete();
      for (int i = 0; i < 122; i++) push(DW'(i));
      m_ready = 1'b1;
      first = -1; last = -1; nl = 0;
      for (int i = 0; i < 300 && acc < 122; i++) begin
         tick(r, v, d, l);
         if (v) begin
            if (first < 0) first = i;
            last = i;
            if (l) begin
               nl++;
               chk("stream_last_pos", d, (nl == 1) ? 60 : 121);
            end
         end
      end
      chk("stream_count", acc, 122);
      chk("stream_latency", first, 2);
      chk("stream_span", last - first, 121);
      chk("stream_lasts", nl, 2);
      chk("stream_row_cnt", int'(row_cnt), 2);

      // Backpressure: two reads then stall, word 10 held.
      do_reset();
      m_ready = 1'b0;
      for (int i = 10; i < 15; i++) push(DW'(i));
      nrd = 0;
      for (int i = 0; i < 10; i++) begin
         tick(r, v, d, l);
         if (r) nrd++;
      end
      chk("bp_rd_pulses", nrd, 2);
      chk("bp_held_valid", int'(m_valid), 1);
      chk("bp_held_data", int'(m_data), 10);
      m_ready = 1'b1;
      n = 0; first = -1; last = -1;
      for (int i = 0; i < 20 && n < 5; i++) begin
         tick(r, v, d, l);
         if (v) begin
            chk($sformatf("bp_word%0d", n), d, 10 + n);
            if (first < 0) first = i;
            last = i;
            n++;
         end
      end
      chk("bp_words", n, 5);
      chk("bp_span", last - first, 4);

      // Random ready over 200 random words.
      do_reset();
      for (int i = 0; i < 200; i++) push(DW'($urandom));
      nl = 0;
      for (int i = 0; i < 4000 && acc < 200; i++) begin
         m_ready = 1'($urandom_range(0, 1));
         tick(r, v, d, l);
         if (v && m_ready && l) nl++;
      end
      chk("rand_count", acc, 200);
      chk("rand_lasts", nl, 3);

      // Clear in the cycle after a read: the returning word is discarded.
      m_ready = 1'b0;
      for (int i = 100; i < 105; i++) push(DW'(i));
      tick(r, v, d, l);
      chk("clr_pre_rd_en", int'(r), 1);
      clear = 1'b1;
      tick(r, v, d, l);
      clear = 1'b0;
      tick(r, v, d, l);
      chk("clr_valid_after", int'(v), 0);
      chk("clr_row_cnt", int'(row_cnt), 0);
      m_ready = 1'b1;
      got = -1;
      for (int i = 0; i < 10 && got < 0; i++) begin
         tick(r, v, d, l);
         if (v) got = d;
      end
      chk("clr_first_word", got, 101);
      for (int i = 0; i < 20 && (fq.size() > 0 || exp_q.size() > 0); i++) tick(r, v, d, l);
      chk("clr_drained", acc, 4);

      // Empty FIFO: nothing issued, nothing valid.
      do_reset();
      nrd = 0; nv = 0;
      for (int i = 0; i < 20; i++) begin
         tick(r, v, d, l);
         if (r) nrd++;
         if (v) nv++;
      end
      chk("empty_rd_pulses", nrd, 0);
      chk("empty_valids", nv, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/sync_fifo_stream_reader.md
# sync_fifo_stream_reader

Read-side controller for the conv kernel's synchronous FIFOs (line buffers). It issues read strobes into a FIFO with registered, one-cycle read latency and re-times the returned words into a valid/ready stream for the downstream window and MAC logic. It absorbs the FIFO read latency with a 2-entry skid buffer, so no word is lost under backpressure. It also tags row boundaries and counts completed rows.

## Interface
- DATA_WIDTH, 25, width of FIFO words and stream data
- ROW_LEN, 61, words per row; sets the m_last position (must be ≥ 1)
- CNT_WIDTH, 8, width of the row counter
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- clear  in  1  synchronous flush of reader state; does not touch FIFO contents
- fifo_empty  in  1  FIFO empty status
- fifo_rd_en  out  1  FIFO read strobe; FIFO data appears on fifo_data the following cycle
- fifo_data  in  DATA_WIDTH  FIFO registered read data
- m_valid  out  1  stream word valid
- m_ready  in  1  downstream accept
- m_data  out  DATA_WIDTH  stream word
- m_last  out  1  high with the last word of each row
- row_cnt  out  CNT_WIDTH  completed rows; wraps modulo 2^CNT_WIDTH

## Operation
- State registers:
  - slot0: output word, drives m_data.
  - slot1: skid word.
  - occ: number of valid slots, 0..2.
  - inflight: 1 when a read was issued in the previous cycle.
  - col: 0..ROW_LEN-1.
  - row_cnt.
- pop = m_valid & m_ready.
- m_valid = (occ != 0) & ~clear.
- fifo_rd_en = ~rst & ~clear & ~fifo_empty & ((occ + inflight − pop) ≤ 1).
  - This guarantees occ + inflight ≤ 2 at all times. A read is never issued without guaranteed space.
  - Under continuous m_ready, one read is issued per cycle, giving full throughput.
- Data ordering:
  - Returned word (inflight=1) is written into the lowest free slot after the pop is applied.
  - On pop with occ=2, slot1 shifts to slot0.
  - Order is strictly FIFO order. No duplication, no drop.
- m_last = m_valid & (col == ROW_LEN−1). It is combinational from registered col.
- On each pop:
  - col increments.
  - At ROW_LEN−1, col wraps to 0 and row_cnt increments (wrapping).
- clear (synchronous, priority over everything except rst):
  - occ←0, inflight←0, col←0, row_cnt←0.
  - A word returning in the cycle after clear is discarded.
  - fifo_rd_en is 0 and m_valid is 0 during clear.
  - No pop is counted in a clear cycle.
- Reset:
  - All registers are 0. m_valid=0, m_data=0, m_last=0, fifo_rd_en=0, row_cnt=0.
  - Reset mid-operation drops all buffered and in-flight words. The FIFO's own read pointer has already advanced for those words; the top level flushes or resets the FIFO alongside.
- ROW_LEN=1: every word carries m_last, and row_cnt increments on every pop.

## Timing
- Cycle N: fifo_empty=0 and space available, so fifo_rd_en=1.
- Cycle N+1: word on fifo_data; captured at the end of N+1.
- Cycle N+2: m_valid=1 with that word. Latency from the first non-empty cycle to the first m_valid is 2 cycles.
- Steady state with m_ready=1: occ=1, inflight=1, one word per cycle, no bubbles.
- m_ready low:
  - At most 2 reads are outstanding or buffered.
  - fifo_rd_en deasserts within 2 cycles and stays low until a pop frees space.
- fifo_empty only gates issue. The FIFO must not be written and read such that its empty flag lies; the reader never asserts fifo_rd_en while fifo_empty=1.
- m_data, m_valid and m_last are stable while m_valid=1 and m_ready=0.

## Test plan
- Reset: assert rst with the FIFO holding 3 words -> fifo_rd_en=0, m_valid=0, m_data=0, m_last=0, row_cnt=0 throughout reset. After release, first m_valid appears 2 cycles later.
- Streaming: ROW_LEN=61, FIFO preloaded with 0..121, m_ready=1 -> m_valid continuous for 122 cycles, data 0..121 in order, m_last exactly on 60 and 121, final row_cnt=2.
- Backpressure: FIFO holds 10..14, m_ready=0 for 10 cycles -> exactly 2 fifo_rd_en pulses, m_data=10 held stable. Release m_ready -> 10,11,12,13,14 with no gaps after the first, no loss or duplicate.
- Random ready: 200 words, m_ready random 50% -> output sequence equals input sequence; occ+inflight never exceeds 2; each m_last on every 61st accepted word.
- Empty FIFO: fifo_empty=1 for 20 cycles -> fifo_rd_en never asserted, m_valid=0.
- Clear with read in flight: pulse clear in the cycle after a fifo_rd_en -> the returned word is discarded, m_valid=0 next cycle, col and row_cnt=0. The next read delivers the next FIFO word with correct m_last counting from 0.
